// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between pipeline WB and the long-latency unit,
// with a busy scoreboard used by decode for RAW/WAW stalls.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_valid,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_stall,
   input  logic        i_ll_valid,
   input  logic [4:0]  i_ll_addr,
   input  logic [31:0] i_ll_data,
   output logic        o_ll_ready,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_rd,
   input  logic [4:0]  i_dec_rs1,
   input  logic [4:0]  i_dec_rs2,
   input  logic [4:0]  i_dec_rd,
   output logic        o_dec_stall,
   output logic        o_rd_wren,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic [31:0] o_busy_mask
);

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   logic [31:0] busy;
   logic [31:0] busy_nxt;
   logic [3:0]  starve_cnt;
   logic [3:0]  starve_nxt;
   logic        ll_pri;
   logic        gnt_ll;
   logic        gnt_wb;

   assign ll_pri = i_ll_valid && (starve_cnt == LIM);

   // Grant is gated by reset so every handshake output is low while held in reset
   always_comb begin
      gnt_ll = 1'b0;
      gnt_wb = 1'b0;
      if (i_rst_n) begin
         if (ll_pri)
            gnt_ll = 1'b1;
         else if (i_wb_valid)
            gnt_wb = 1'b1;
         else if (i_ll_valid)
            gnt_ll = 1'b1;
      end
   end

   assign o_ll_ready = gnt_ll;
   assign o_wb_stall = i_wb_valid && gnt_ll;

   always_comb begin
      o_rd_wren = 1'b0;
      o_rd_addr = 5'd0;
      o_rd_data = 32'd0;
      if (gnt_ll) begin
         o_rd_addr = i_ll_addr;
         o_rd_data = i_ll_data;
         o_rd_wren = (i_ll_addr != 5'd0);
      end else if (gnt_wb) begin
         o_rd_addr = i_wb_addr;
         o_rd_data = i_wb_data;
         o_rd_wren = (i_wb_addr != 5'd0);
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (!i_ll_valid || gnt_ll)
         starve_nxt = 4'd0;
      else if (starve_cnt != LIM)
         starve_nxt = starve_cnt + 4'd1;
   end

   // Set is applied after clear so a same-register set wins
   always_comb begin
      busy_nxt = busy;
      if (i_ll_valid && gnt_ll)
         busy_nxt[i_ll_addr] = 1'b0;
      if (i_issue_valid && (i_issue_rd != 5'd0))
         busy_nxt[i_issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy       <= 32'd0;
         starve_cnt <= 4'd0;
      end else begin
         busy       <= busy_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // busy[0] is never set, so index 0 contributes nothing
   assign o_dec_stall = i_rst_n &&
                        (busy[i_dec_rs1] | busy[i_dec_rs2] | busy[i_dec_rd]);
   assign o_busy_mask = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_wb_valid;
   logic [4:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_stall;
   logic        i_ll_valid;
   logic [4:0]  i_ll_addr;
   logic [31:0] i_ll_data;
   logic        o_ll_ready;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd;
   logic [4:0]  i_dec_rs1;
   logic [4:0]  i_dec_rs2;
   logic [4:0]  i_dec_rd;
   logic        o_dec_stall;
   logic        o_rd_wren;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic [31:0] o_busy_mask;

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_wb_valid    (i_wb_valid),
      .i_wb_addr     (i_wb_addr),
      .i_wb_data     (i_wb_data),
      .o_wb_stall    (o_wb_stall),
      .i_ll_valid    (i_ll_valid),
      .i_ll_addr     (i_ll_addr),
      .i_ll_data     (i_ll_data),
      .o_ll_ready    (o_ll_ready),
      .i_issue_valid (i_issue_valid),
      .i_issue_rd    (i_issue_rd),
      .i_dec_rs1     (i_dec_rs1),
      .i_dec_rs2     (i_dec_rs2),
      .i_dec_rd      (i_dec_rd),
      .o_dec_stall   (o_dec_stall),
      .o_rd_wren     (o_rd_wren),
      .o_rd_addr     (o_rd_addr),
      .o_rd_data     (o_rd_data),
      .o_busy_mask   (o_busy_mask)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_wb_valid    = 1'b0;
      i_wb_addr     = 5'd0;
      i_wb_data     = 32'd0;
      i_ll_valid    = 1'b0;
      i_ll_addr     = 5'd0;
      i_ll_data     = 32'd0;
      i_issue_valid = 1'b0;
      i_issue_rd    = 5'd0;
      i_dec_rs1     = 5'd0;
      i_dec_rs2     = 5'd0;
      i_dec_rd      = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   typedef struct {
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        rdy;
      logic        stl;
      logic        wen;
      logic [4:0]  a;
      logic [31:0] d;
   } vec_t;

   vec_t tbl[7];

   // behavioural model state
   bit [31:0] m_busy;
   int        m_wait;
   int        m_age;

   function automatic logic [4:0] pick(input bit want_busy);
      for (int t = 0; t < 40; t++) begin
         logic [4:0] r;
         r = 5'($urandom_range(1, 31));
         if (m_busy[r] == want_busy)
            return r;
      end
      return 5'd0;
   endfunction

   initial begin
      tbl[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
      tbl[1] = '{1'b1, 5'd3,  32'hAAAA_0003, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b1, 5'd3,  32'hAAAA_0003};
      tbl[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8, 32'h5555_0008,
                 1'b1, 1'b0, 1'b1, 5'd8,  32'h5555_0008};
      tbl[3] = '{1'b1, 5'd4,  32'h1234_5678, 1'b1, 5'd9, 32'h8765_4321,
                 1'b0, 1'b0, 1'b1, 5'd4,  32'h1234_5678};
      tbl[4] = '{1'b1, 5'd0,  32'hCAFE_0000, 1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0, 5'd0,  32'hCAFE_0000};
      tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'hBEEF_0000,
                 1'b1, 1'b0, 1'b0, 5'd0,  32'hBEEF_0000};
      tbl[6] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h0000_001F,
                 1'b1, 1'b0, 1'b1, 5'd31, 32'h0000_001F};

      do_reset();
      chk("reset_mask", o_busy_mask, 32'h0);
      chk("reset_dec_stall", {31'd0, o_dec_stall}, 32'd0);

      // combinational vectors from the post-reset state, no clock edges
      for (int i = 0; i < 7; i++) begin
         i_wb_valid = tbl[i].wv;
         i_wb_addr  = tbl[i].wa;
         i_wb_data  = tbl[i].wd;
         i_ll_valid = tbl[i].lv;
         i_ll_addr  = tbl[i].la;
         i_ll_data  = tbl[i].ld;
         #1;
         chk($sformatf("vec%0d_ready", i), {31'd0, o_ll_ready}, {31'd0, tbl[i].rdy});
         chk($sformatf("vec%0d_stall", i), {31'd0, o_wb_stall}, {31'd0, tbl[i].stl});
         chk($sformatf("vec%0d_wren", i), {31'd0, o_rd_wren}, {31'd0, tbl[i].wen});
         chk($sformatf("vec%0d_addr", i), {27'd0, o_rd_addr}, {27'd0, tbl[i].a});
         chk($sformatf("vec%0d_data", i), o_rd_data, tbl[i].d);
      end

      // issue then writeback
      do_reset();
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd5;
      step();
      i_issue_valid = 1'b0;
      i_dec_rs1     = 5'd5;
      #1;
      chk("iw_stall_after_issue", {31'd0, o_dec_stall}, 32'd1);
      chk("iw_mask", o_busy_mask, 32'h0000_0020);
      i_ll_valid = 1'b1;
      i_ll_addr  = 5'd5;
      i_ll_data  = 32'hDEAD_BEEF;
      #1;
      chk("iw_wren", {31'd0, o_rd_wren}, 32'd1);
      chk("iw_addr", {27'd0, o_rd_addr}, 32'd5);
      chk("iw_data", o_rd_data, 32'hDEAD_BEEF);
      chk("iw_stall_same_cycle", {31'd0, o_dec_stall}, 32'd1);
      step();
      i_ll_valid = 1'b0;
      #1;
      chk("iw_stall_next_cycle", {31'd0, o_dec_stall}, 32'd0);

      // contention: LL wins every LIMIT+1 cycles
      do_reset();
      i_wb_valid = 1'b1;
      i_wb_addr  = 5'd2;
      i_wb_data  = 32'h0000_0222;
      i_ll_valid = 1'b1;
      i_ll_addr  = 5'd6;
      i_ll_data  = 32'h0000_0666;
      for (int c = 0; c < 3 * (LIMIT + 1); c++) begin
         logic exp_ll;
         exp_ll = ((c % (LIMIT + 1)) == LIMIT);
         #1;
         chk($sformatf("cont%0d_ready", c), {31'd0, o_ll_ready}, {31'd0, exp_ll});
         chk($sformatf("cont%0d_wbstall", c), {31'd0, o_wb_stall}, {31'd0, exp_ll});
         chk($sformatf("cont%0d_addr", c), {27'd0, o_rd_addr},
             exp_ll ? 32'd6 : 32'd2);
         step();
      end

      // simultaneous set / clear, then x0 issue
      do_reset();
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd7;
      step();
      i_ll_valid = 1'b1;
      i_ll_addr  = 5'd7;
      i_ll_data  = 32'h7777_7777;
      #1;
      chk("sc_ready", {31'd0, o_ll_ready}, 32'd1);
      step();
      i_ll_valid    = 1'b0;
      i_issue_valid = 1'b0;
      #1;
      chk("sc_set_wins", o_busy_mask, 32'h0000_0080);
      i_ll_valid    = 1'b1;
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd9;
      step();
      i_ll_valid    = 1'b0;
      i_issue_rd    = 5'd0;
      #1;
      chk("sc_clear7_set9", o_busy_mask, 32'h0000_0200);
      step();
      i_issue_valid = 1'b0;
      #1;
      chk("x0_issue", o_busy_mask, 32'h0000_0200);

      // asynchronous reset mid-run
      do_reset();
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd5;
      step();
      i_issue_rd    = 5'd10;
      step();
      i_issue_valid = 1'b0;
      i_dec_rs1     = 5'd5;
      i_ll_valid    = 1'b1;
      i_ll_addr     = 5'd10;
      i_ll_data     = 32'h0A0A_0A0A;
      i_wb_valid    = 1'b1;
      i_wb_addr     = 5'd3;
      i_wb_data     = 32'h3333_3333;
      #1;
      chk("rst_pre_mask", o_busy_mask, 32'h0000_0420);
      chk("rst_pre_stall", {31'd0, o_dec_stall}, 32'd1);
      #1 i_rst_n = 1'b0;
      #1;
      chk("rst_wren", {31'd0, o_rd_wren}, 32'd0);
      chk("rst_ready", {31'd0, o_ll_ready}, 32'd0);
      chk("rst_wbstall", {31'd0, o_wb_stall}, 32'd0);
      chk("rst_decstall", {31'd0, o_dec_stall}, 32'd0);
      chk("rst_mask", o_busy_mask, 32'h0);
      idle_inputs();
      @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      #1;
      chk("rst_release_mask", o_busy_mask, 32'h0);

      // randomized run against the behavioural model
      do_reset();
      m_busy = '0;
      m_wait = 0;
      m_age  = 0;
      begin
         logic last_ready;
         logic last_stall;
         last_ready = 1'b0;
         last_stall = 1'b0;
         for (int c = 0; c < 400; c++) begin
            logic        e_ll;
            logic        e_wb;
            logic        e_wen;
            logic [4:0]  e_addr;
            logic [31:0] e_data;
            logic        e_dec;
            if (!(i_ll_valid && !last_ready)) begin
               i_ll_valid = ($urandom_range(0, 2) != 0);
               i_ll_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : pick(1'b1);
               i_ll_data  = $urandom;
            end
            if (!(i_wb_valid && last_stall)) begin
               i_wb_valid = ($urandom_range(0, 3) != 0);
               i_wb_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : pick(1'b0);
               i_wb_data  = $urandom;
            end
            i_issue_rd    = 5'($urandom_range(0, 31));
            i_issue_valid = ($urandom_range(0, 2) == 0) &&
                            !m_busy[i_issue_rd] &&
                            !(i_wb_valid && i_issue_rd == i_wb_addr);
            i_dec_rs1 = 5'($urandom_range(0, 31));
            i_dec_rs2 = 5'($urandom_range(0, 31));
            i_dec_rd  = 5'($urandom_range(0, 31));
            #1;
            e_ll   = i_ll_valid && (m_wait == LIMIT || !i_wb_valid);
            e_wb   = i_wb_valid && !e_ll;
            e_addr = e_ll ? i_ll_addr : (e_wb ? i_wb_addr : 5'd0);
            e_data = e_ll ? i_ll_data : (e_wb ? i_wb_data : 32'd0);
            e_wen  = (e_ll || e_wb) && e_addr != 5'd0;
            e_dec  = (i_dec_rs1 != 0 && m_busy[i_dec_rs1]) ||
                     (i_dec_rs2 != 0 && m_busy[i_dec_rs2]) ||
                     (i_dec_rd  != 0 && m_busy[i_dec_rd]);
            chk("rnd_ready", {31'd0, o_ll_ready}, {31'd0, e_ll});
            chk("rnd_wbstall", {31'd0, o_wb_stall}, {31'd0, i_wb_valid && e_ll});
            chk("rnd_wren", {31'd0, o_rd_wren}, {31'd0, e_wen});
            chk("rnd_addr", {27'd0, o_rd_addr}, {27'd0, e_addr});
            chk("rnd_data", o_rd_data, e_data);
            chk("rnd_dec_stall", {31'd0, o_dec_stall}, {31'd0, e_dec});
            chk("rnd_mask", o_busy_mask, m_busy);
            if (i_ll_valid && e_ll) begin
               chk("rnd_starve_bound", (m_age + 1 <= LIMIT + 1) ? 32'd1 : 32'(m_age + 1), 32'd1);
            end
            @(posedge i_clk);
            if (i_ll_valid && !e_ll) begin
               m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
               m_age++;
            end else begin
               m_wait = 0;
               m_age  = 0;
            end
            if (i_ll_valid && e_ll)
               m_busy[i_ll_addr] = 1'b0;
            if (i_issue_valid && i_issue_rd != 5'd0)
               m_busy[i_issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
            last_ready = e_ll;
            last_stall = i_wb_valid && e_ll;
            #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32x32 integer register file between two writeback sources: the in-order pipeline writeback and the long-latency unit (divider/load miss). The long-latency unit uses a valid/ready handshake, and a starvation counter guarantees it a slot. The block also holds a 32-bit busy scoreboard of registers with outstanding long-latency results, so decode can stall on RAW and WAW hazards. It sits between the WB stage, the long-latency unit and the register file write port.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a valid long-latency request may be denied before it takes priority (legal range 1..15).

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wb_valid  in  1  pipeline writeback request.
- i_wb_addr  in  5  pipeline destination register.
- i_wb_data  in  32  pipeline writeback data.
- o_wb_stall  out  1  pipeline must hold its WB request stable this cycle.
- i_ll_valid  in  1  long-latency result valid.
- i_ll_addr  in  5  long-latency destination register.
- i_ll_data  in  32  long-latency result data.
- o_ll_ready  out  1  long-latency result accepted this cycle.
- i_issue_valid  in  1  a long-latency op issues this cycle.
- i_issue_rd  in  5  destination register of the issuing op.
- i_dec_rs1  in  5  decode source register 1.
- i_dec_rs2  in  5  decode source register 2.
- i_dec_rd  in  5  decode destination register.
- o_dec_stall  out  1  decode must stall on a hazard.
- o_rd_wren  out  1  register file write enable.
- o_rd_addr  out  5  register file write address.
- o_rd_data  out  32  register file write data.
- o_busy_mask  out  32  scoreboard; bit r = 1 means register r is pending.

## Operation
- **State:** busy[31:0] and starve_cnt (4 bits). Both clear to 0 on reset.
- **LL priority:** ll_pri = i_ll_valid && (starve_cnt == STARVE_LIMIT).
- **Grant, combinational, one writer per cycle:**
  - If ll_pri: LL is granted.
  - Else if i_wb_valid: WB is granted.
  - Else if i_ll_valid: LL is granted.
  - Else: no grant.
- **Outputs from the grant:**
  - o_ll_ready = LL granted.
  - o_wb_stall = i_wb_valid && LL granted.
- **Write port:**
  - Drives the granted source's addr/data.
  - o_rd_wren = granted && addr != 0.
  - A grant to x0 still completes the handshake but performs no write.
  - With no grant: o_rd_wren = 0, and o_rd_addr/o_rd_data = 0.
- **Starvation counter:**
  - Increments (saturating at STARVE_LIMIT) when i_ll_valid && !o_ll_ready.
  - Clears when o_ll_ready = 1 or i_ll_valid = 0.
- **Scoreboard set:** on i_issue_valid with i_issue_rd != 0, busy[i_issue_rd] <= 1.
- **Scoreboard clear:** on an LL handshake (i_ll_valid && o_ll_ready), busy[i_ll_addr] <= 0.
- **Same-register set and clear in one cycle:** set wins.
- **busy[0]:** always 0.
- **o_dec_stall:** busy[i_dec_rs1] | busy[i_dec_rs2] | busy[i_dec_rd], with any index 0 contributing 0.
- **o_busy_mask:** equals busy.
- **Protocol rules (checked by assertions, not by the RTL):**
  - Once i_ll_valid rises, i_ll_addr/i_ll_data are held stable until o_ll_ready.
  - Under o_wb_stall, i_wb_* are held stable.
  - Issuing to a register that is already busy is prevented by o_dec_stall.
  - A pipeline WB to a busy register is illegal.

## Timing
- **Grant and write port:** zero latency, combinational from the inputs. The register file captures the write at the next rising edge.
- **Scoreboard:** busy updates at the rising edge, so o_dec_stall sees a new issue from the next cycle.
- **Clear timing:** on the cycle a busy register's LL result is written, o_dec_stall is still 1 for it. It drops the following cycle, when the register file already holds the new value. No bypass is provided.
- **Starvation bound:** a continuously valid LL request is accepted within at most STARVE_LIMIT+1 cycles.
- **Reset asserted (asynchronous, mid-transfer included):**
  - busy and starve_cnt clear immediately.
  - o_rd_wren, o_ll_ready, o_wb_stall and o_dec_stall are forced to 0; o_busy_mask = 0.
  - An in-flight LL result is dropped.
- **After reset release:** normal operation from the first rising edge.

## Test plan
- **Reset:** assert i_rst_n=0 mid-run with busy=32'h0000_0420 -> all outputs 0 immediately; o_busy_mask=0 after release.
- **Issue then writeback:** issue rd=5; next cycle decode rs1=5 -> o_dec_stall=1. LL writes x5=32'hDEAD_BEEF -> o_rd_wren=1, addr=5, stall still 1 that cycle, 0 the next.
- **Contention:** i_wb_valid and i_ll_valid continuously high, STARVE_LIMIT=4 -> WB granted cycles 0-3; LL granted cycle 4 with o_wb_stall=1; counter returns to 0; pattern repeats.
- **x0 handling:** issue rd=0 -> busy stays 0. LL result to x0 -> o_ll_ready=1, o_rd_wren=0. Pipeline WB to x0 -> o_rd_wren=0.
- **Simultaneous set/clear:** LL handshake for x7 and issue rd=7 in the same cycle -> busy[7]=1 afterwards. Handshake for x7 plus issue rd=9 -> busy[7]=0, busy[9]=1.
- **Idle LL:** i_ll_valid=1 with i_wb_valid=0 -> LL granted the same cycle and o_wb_stall=0.
